// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the F/D/E/M/W pipeline: stall/flush/forwarding control,
// a one-deep scoreboard for multi-cycle mul/div ops, and a stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic                  use_rs_d,
  input  logic                  use_rt_d,
  input  logic                  branch_d,
  input  logic                  md_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rt_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  reg_write_e,
  input  logic                  mem_to_reg_e,
  input  logic                  md_issue_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  input  logic                  branch_taken_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  fwd_a_d,
  output logic                  fwd_b_d,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  md_busy,
  output logic [REG_ADDR_W-1:0] md_rd,
  output logic                  md_done,
  output logic [CNT_W-1:0]      perf_stall_cycles
);

  localparam int        MD_CNT_W = 4;
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t            md_state;
  logic [MD_CNT_W-1:0]  md_cnt;

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  // Register 0 is hardwired zero, so it never matches as a hazard source.
  function automatic logic match(input logic [REG_ADDR_W-1:0] x,
                                 input logic [REG_ADDR_W-1:0] y);
    return (x == y) && (y != '0);
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [REG_ADDR_W-1:0] src);
    if (reg_write_m && match(src, rd_m))
      return 2'd1;
    else if (reg_write_w && match(src, rd_w))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  always_comb begin
    lw_stall = mem_to_reg_e && reg_write_e &&
               ((use_rs_d && match(rs_d, rd_e)) || (use_rt_d && match(rt_d, rd_e)));

    br_stall = branch_d &&
               ((reg_write_e && (match(rs_d, rd_e) || match(rt_d, rd_e))) ||
                (mem_to_reg_m && reg_write_m &&
                 (match(rs_d, rd_m) || match(rt_d, rd_m))));

    // Released in the md_done cycle: the regfile write-through is visible to D.
    md_stall = md_busy && !md_done &&
               ((use_rs_d && match(rs_d, md_rd)) ||
                (use_rt_d && match(rt_d, md_rd)) || md_d);

    stall = lw_stall || br_stall || md_stall;
  end

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  assign flush_d = branch_taken_d && !stall;

  assign fwd_a_d = reg_write_m && match(rs_d, rd_m) && !mem_to_reg_m;
  assign fwd_b_d = reg_write_m && match(rt_d, rd_m) && !mem_to_reg_m;
  assign fwd_a_e = fwd_e_sel(rs_e);
  assign fwd_b_e = fwd_e_sel(rt_e);

  // md_busy covers BUSY plus the md_done cycle, so it is held as its own flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      md_busy  <= 1'b0;
      md_rd    <= '0;
      md_done  <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (md_state)
        MD_IDLE: begin
          if (md_issue_e) begin
            md_state <= MD_BUSY;
            md_cnt   <= MD_LOAD;
            md_rd    <= rd_e;
            md_busy  <= 1'b1;
          end else begin
            md_busy  <= 1'b0;
          end
        end
        MD_BUSY: begin
          if (md_cnt == MD_CNT_W'(1)) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
            md_done  <= 1'b1;
          end else begin
            md_cnt   <= md_cnt - MD_CNT_W'(1);
          end
        end
        default: begin
          md_state <= MD_IDLE;
          md_cnt   <= '0;
          md_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      perf_stall_cycles <= '0;
    else if (stall && (perf_stall_cycles != '1))
      perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: stimulus pushes expected outputs
// into a queue, a negedge monitor pops and compares them.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w;
  logic       use_rs_d, use_rt_d, branch_d, md_d;
  logic       reg_write_e, mem_to_reg_e, md_issue_e;
  logic       reg_write_m, mem_to_reg_m, reg_write_w, branch_taken_d;
  logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       md_busy, md_done;
  logic [4:0] md_rd;
  logic [3:0] perf_stall_cycles;

  int total = 0;
  int bad   = 0;

  localparam int M_ST = 1, M_FD = 2, M_FWD = 4, M_FWE = 8, M_MD = 16, M_RD = 32, M_PF = 64;

  typedef struct {
    int         m;
    logic       st, fd, fad, fbd;
    logic [1:0] fae, fbe;
    logic       bz, dn;
    logic [4:0] rd;
    logic [3:0] pf;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .branch_d(branch_d), .md_d(md_d),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .md_issue_e(md_issue_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .branch_taken_d(branch_taken_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .md_busy(md_busy), .md_rd(md_rd), .md_done(md_done),
    .perf_stall_cycles(perf_stall_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if ((e.m & M_ST) != 0)  chk("stall_f/stall_d/flush_e", {29'd0, stall_f, stall_d, flush_e}, {29'd0, {3{e.st}}});
      if ((e.m & M_FD) != 0)  chk("flush_d", 32'(flush_d), 32'(e.fd));
      if ((e.m & M_FWD) != 0) chk("fwd_d", {30'd0, fwd_a_d, fwd_b_d}, {30'd0, e.fad, e.fbd});
      if ((e.m & M_FWE) != 0) chk("fwd_e", {28'd0, fwd_a_e, fwd_b_e}, {28'd0, e.fae, e.fbe});
      if ((e.m & M_MD) != 0)  chk("md_busy/md_done", {30'd0, md_busy, md_done}, {30'd0, e.bz, e.dn});
      if ((e.m & M_RD) != 0)  chk("md_rd", 32'(md_rd), 32'(e.rd));
      if ((e.m & M_PF) != 0)  chk("perf_stall_cycles", 32'(perf_stall_cycles), 32'(e.pf));
    end
  end

  task automatic ex(input int m, input logic st, input logic fd, input logic fad, input logic fbd,
                    input logic [1:0] fae, input logic [1:0] fbe, input logic bz, input logic dn,
                    input logic [4:0] rd, input logic [3:0] pf);
    exp_t e;
    e.m = m; e.st = st; e.fd = fd; e.fad = fad; e.fbd = fbd; e.fae = fae; e.fbe = fbe;
    e.bz = bz; e.dn = dn; e.rd = rd; e.pf = pf;
    q.push_back(e);
  endtask

  task automatic idle();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    use_rs_d = 0; use_rt_d = 0; branch_d = 0; md_d = 0;
    reg_write_e = 0; mem_to_reg_e = 0; md_issue_e = 0;
    reg_write_m = 0; mem_to_reg_m = 0; reg_write_w = 0; branch_taken_d = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int SP = M_ST | M_PF;
  localparam int MDP = M_ST | M_MD | M_RD | M_PF;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; idle();
    repeat (2) @(posedge clk);
    #1; rst = 0;

    // reset state
    idle(); ex(SP | M_FD | M_FWD | M_FWE | M_MD | M_RD, 0,0,0,0,0,0,0,0,0,0); tick();

    // load-use
    idle(); mem_to_reg_e = 1; reg_write_e = 1; rd_e = 5; rs_d = 5; use_rs_d = 1;
    ex(SP | M_FD, 1,0,0,0,0,0,0,0,0,0); tick();
    idle(); ex(SP, 0,0,0,0,0,0,0,0,0,1); tick();
    idle(); mem_to_reg_e = 1; reg_write_e = 1; rd_e = 5; rs_d = 5; use_rs_d = 0;
    ex(SP, 0,0,0,0,0,0,0,0,0,1); tick();
    idle(); mem_to_reg_e = 1; reg_write_e = 1; rd_e = 5; rt_d = 5; use_rt_d = 1;
    ex(SP, 1,0,0,0,0,0,0,0,0,1); tick();
    idle(); mem_to_reg_e = 1; reg_write_e = 1; rd_e = 0; rs_d = 0; use_rs_d = 1;
    ex(SP, 0,0,0,0,0,0,0,0,0,2); tick();

    // E-stage forwarding priority
    idle(); reg_write_m = 1; rd_m = 7; reg_write_w = 1; rd_w = 7; rs_e = 7; rt_e = 2;
    ex(M_FWE | M_FWD, 0,0,0,0,1,0,0,0,0,0); tick();
    idle(); reg_write_m = 1; rd_m = 3; reg_write_w = 1; rd_w = 7; rs_e = 7; rt_e = 3;
    ex(M_FWE, 0,0,0,0,2,1,0,0,0,0); tick();
    idle(); reg_write_m = 1; rd_m = 0; reg_write_w = 1; rd_w = 0; rs_e = 0; rt_e = 0;
    ex(M_FWE, 0,0,0,0,0,0,0,0,0,0); tick();
    idle(); reg_write_w = 0; rd_w = 7; rs_e = 7;
    ex(M_FWE, 0,0,0,0,0,0,0,0,0,0); tick();

    // branch operand hazards and flush
    idle(); branch_d = 1; rs_d = 4; use_rs_d = 1; reg_write_e = 1; rd_e = 4; branch_taken_d = 1;
    ex(SP | M_FD | M_FWD, 1,0,0,0,0,0,0,0,0,2); tick();
    idle(); branch_d = 1; rs_d = 4; use_rs_d = 1; reg_write_m = 1; rd_m = 4; branch_taken_d = 1;
    ex(SP | M_FD | M_FWD, 0,1,1,0,0,0,0,0,0,3); tick();
    idle(); ex(SP | M_FD, 0,0,0,0,0,0,0,0,0,3); tick();
    idle(); branch_d = 1; rt_d = 6; use_rt_d = 1; reg_write_m = 1; mem_to_reg_m = 1; rd_m = 6;
    ex(SP | M_FD | M_FWD, 1,0,0,0,0,0,0,0,0,3); tick();
    idle(); reg_write_e = 1; rd_e = 4; rs_d = 4; use_rs_d = 1;
    ex(SP, 0,0,0,0,0,0,0,0,0,4); tick();

    // MD RAW hazard on rd 9
    idle(); md_issue_e = 1; rd_e = 9;
    ex(M_ST | M_MD | M_RD | M_PF, 0,0,0,0,0,0,0,0,0,4); tick();
    idle(); rs_d = 9; use_rs_d = 1; ex(MDP, 1,0,0,0,0,0,1,0,9,4); tick();
    idle(); rs_d = 9; use_rs_d = 1; ex(MDP, 1,0,0,0,0,0,1,0,9,5); tick();
    idle(); rs_d = 9; use_rs_d = 1; ex(MDP, 1,0,0,0,0,0,1,0,9,6); tick();
    idle(); rs_d = 9; use_rs_d = 1; ex(MDP, 0,0,0,0,0,0,1,1,9,7); tick();
    idle(); md_d = 1; ex(M_ST | M_MD | M_PF, 0,0,0,0,0,0,0,0,0,7); tick();

    // MD structural hazard, ignored issue while busy, back-to-back issue on done
    idle(); md_issue_e = 1; rd_e = 10; ex(M_ST | M_MD | M_PF, 0,0,0,0,0,0,0,0,0,7); tick();
    idle(); md_d = 1; ex(MDP, 1,0,0,0,0,0,1,0,10,7); tick();
    idle(); md_d = 1; md_issue_e = 1; rd_e = 11; ex(MDP, 1,0,0,0,0,0,1,0,10,8); tick();
    idle(); md_d = 1; ex(MDP, 1,0,0,0,0,0,1,0,10,9); tick();
    idle(); md_d = 1; md_issue_e = 1; rd_e = 12; ex(MDP, 0,0,0,0,0,0,1,1,10,10); tick();
    idle(); ex(MDP, 0,0,0,0,0,0,1,0,12,10); tick();

    // reset in the middle of an MD op
    idle(); rst = 1; ex(M_MD | M_RD | M_PF, 0,0,0,0,0,0,1,0,12,10); tick();
    rst = 0;
    idle(); rs_d = 12; use_rs_d = 1; ex(MDP, 0,0,0,0,0,0,0,0,0,0); tick();
    idle(); md_issue_e = 1; rd_e = 13; ex(M_MD | M_PF, 0,0,0,0,0,0,0,0,0,0); tick();
    idle(); ex(M_MD | M_RD, 0,0,0,0,0,0,1,0,13,0); tick();
    idle(); ex(M_MD, 0,0,0,0,0,0,1,0,13,0); tick();
    idle(); ex(M_MD, 0,0,0,0,0,0,1,0,13,0); tick();
    idle(); ex(M_MD | M_RD, 0,0,0,0,0,0,1,1,13,0); tick();
    idle(); ex(M_MD | M_PF, 0,0,0,0,0,0,0,0,0,0); tick();

    // counter saturation with CNT_W=4
    for (int i = 0; i < 20; i++) begin
      idle(); mem_to_reg_e = 1; reg_write_e = 1; rd_e = 5; rs_d = 5; use_rs_d = 1;
      ex(SP, 1,0,0,0,0,0,0,0,0, (i > 15) ? 4'd15 : 4'(i)); tick();
    end
    idle(); ex(SP, 0,0,0,0,0,0,0,0,0,15); tick();

    // register 0 is never a hazard or forwarding source
    idle(); mem_to_reg_e = 1; reg_write_e = 1; rd_e = 0; use_rs_d = 1; use_rt_d = 1;
    branch_d = 1; reg_write_m = 1; rd_m = 0; reg_write_w = 1; rd_w = 0;
    ex(SP | M_FWD | M_FWE, 0,0,0,0,0,0,0,0,0,15); tick();

    idle();
    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
